csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR register file for the pipelined RV32 core. It owns the architectural CSRs. It serves the combinational `csr_rd` read that the EX stage's CSRRW/S/C(I) logic consumes, and it commits the resulting `csr_wd` write-back. It also implements trap entry, `mret`, the 64-bit cycle/instret counters and the timer-interrupt pending flag.

## Interface
- `MTVEC_RESET`, 32'h0000_0100: reset value of mtvec.
- `MISA_VALUE`, 32'h4000_0100: read-only misa value (RV32I).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `csr_addr`  in  12  read address from EX.
- `csr_rd`  out  32  combinational read data for `csr_addr`.
- `csr_illegal`  out  1  combinational; high when `csr_addr` is unimplemented.
- `csr_we`  in  1  commit write enable.
- `csr_waddr`  in  12  commit write address.
- `csr_wd`  in  32  commit write data.
- `instr_retire`  in  1  one instruction retired this cycle.
- `trap_valid`  in  1  take exception/interrupt this cycle.
- `trap_pc`  in  32  PC to save in mepc.
- `trap_cause`  in  32  value for mcause.
- `trap_val`  in  32  value for mtval.
- `mret`  in  1  mret committed this cycle.
- `irq_timer`  in  1  level timer interrupt request.
- `irq_pending`  out  1  `mstatus.MIE & mie.MTIE & irq_timer`.
- `trap_vector`  out  32  current mtvec; direct mode only.
- `mepc_out`  out  32  current mepc, used as the mret target.

## Operation
- **Implemented addresses:**
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: read-only `MISA_VALUE`.
  - mie 0x304: only MTIE bit 7 is writable.
  - mtvec 0x305: bits [1:0] forced to 0.
  - mscratch 0x340, mcause 0x342, mtval 0x343: full 32 bits writable.
  - mepc 0x341: bits [1:0] forced to 0.
  - mip 0x344: MTIP bit 7 mirrors `irq_timer`; read-only.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: writable.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82: read-only shadows of the counters.
  - mhartid 0xF14: reads 0.
- Any other address: `csr_rd` = 0 and `csr_illegal` = 1.
- Writes to read-only addresses (addr[11:10]==2'b11, misa, mip) or unimplemented addresses are silently dropped.
- **Reset values (asynchronous):**
  - mstatus MIE = MPIE = 0; mie = 0; mtvec = `MTVEC_RESET`.
  - mscratch, mepc, mcause, mtval = 0; mcycle = minstret = 64'h0.
- **Counters:**
  - mcycle increments by 1 every cycle.
  - minstret increments by 1 when `instr_retire` = 1.
  - Both wrap from 2^64-1 to 0 with no flag.
- **Counter write precedence:** a commit write to either half replaces that half and suppresses the increment for that cycle. The other half holds its value; there is no carry.
- **Trap entry** (`trap_valid`=1), all updated on one edge:
  - mepc <= `trap_pc` & ~3; mcause <= `trap_cause`; mtval <= `trap_val`.
  - MPIE <= MIE; MIE <= 0.
- **mret** (`mret`=1): MIE <= MPIE; MPIE <= 1.
- **Same-cycle priority:** trap > mret > csr write.
  - A lower-priority event that collides with a higher-priority one on the same CSR is dropped.
  - Non-conflicting fields still update. Example: `trap_valid` with a write to mscratch updates both.
- Counters still increment during trap and mret cycles.

## Timing
- `csr_rd`, `csr_illegal`, `irq_pending`, `trap_vector` and `mepc_out` are combinational from registered state and inputs. There is no internal write-to-read bypass; hazards are the pipeline's responsibility.
- Write, trap and mret effects are visible on outputs in the cycle after the capturing edge (1-cycle latency).
- Counter reads return the pre-edge value. After `rst_n` rises, mcycle reads 0 before the first edge and 1 after it.
- Reset asserted mid-operation clears all state immediately, regardless of `clk`. Pending trap, mret and write inputs are lost.
- `irq_pending` follows `irq_timer` combinationally when enabled; it is not latched.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → mtvec reads 32'h100, mstatus reads 32'h1800, mcycle reads 0. Release → mcycle reads 5 after 5 edges.
- **Write/read:** write mtvec=32'h0000_1233 → reads 32'h0000_1230 the next cycle. Write mscratch=32'hDEAD_BEEF → read back exact. Write 0xC00 → ignored. Read 0x7C0 → `csr_rd`=0, `csr_illegal`=1.
- **Trap then mret:**
  - Set MIE=1, then `trap_valid` with pc=32'h0000_2006, cause=32'h8000_0007 → mepc=32'h2004, mcause=32'h8000_0007, MIE=0, MPIE=1.
  - Then `mret` → MIE=1, MPIE=1.
- **Priority:** `trap_valid` + `mret` + write mepc=32'h40 in one cycle → trap values win; mepc=`trap_pc`&~3.
- **Counters:**
  - Preload minstret=32'hFFFF_FFFF, minstreth=0; retire 1 → {h,l}=64'h1_0000_0000.
  - Write mcycle=7 in a cycle → reads 7 the next cycle, not 8.
- **Interrupt:**
  - `irq_timer`=1 with MTIE=1, MIE=0 → `irq_pending`=0 and mip reads 32'h80.
  - Set MIE=1 → `irq_pending`=1.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: combinational CSR read, commit write,
// trap entry, mret, 64-bit cycle/instret counters and timer-interrupt pending.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rd,
    output logic        csr_illegal,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wd,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        irq_timer,
    output logic        irq_pending,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 64;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic            mtie_q, mtie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [CW-1:0]   mcycle_q, mcycle_d;
    logic [CW-1:0]   minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mip_rd;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
    assign mip_rd     = {24'b0, irq_timer, 7'b0};

    assign irq_pending = mie_q & mtie_q & irq_timer;
    assign trap_vector = mtvec_q;
    assign mepc_out    = mepc_q;

    // Combinational read port for the EX stage
    always_comb begin
        csr_rd      = '0;
        csr_illegal = 1'b0;
        case (csr_addr)
            A_MSTATUS:               csr_rd = mstatus_rd;
            A_MISA:                  csr_rd = MISA_VALUE;
            A_MIE:                   csr_rd = {24'b0, mtie_q, 7'b0};
            A_MTVEC:                 csr_rd = mtvec_q;
            A_MSCRATCH:              csr_rd = mscratch_q;
            A_MEPC:                  csr_rd = mepc_q;
            A_MCAUSE:                csr_rd = mcause_q;
            A_MTVAL:                 csr_rd = mtval_q;
            A_MIP:                   csr_rd = mip_rd;
            A_MCYCLE,   A_CYCLE:     csr_rd = mcycle_q[31:0];
            A_MCYCLEH,  A_CYCLEH:    csr_rd = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:   csr_rd = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: csr_rd = minstret_q[63:32];
            A_MHARTID:               csr_rd = '0;
            default:                 csr_illegal = 1'b1;
        endcase
    end

    // Next-state: trap beats mret beats commit write on any shared CSR
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CW'(1);
        minstret_d = minstret_q + CW'(instr_retire);

        if (trap_valid) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = trap_cause;
            mtval_d  = trap_val;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we && csr_waddr == A_MSTATUS) begin
            mie_d  = csr_wd[3];
            mpie_d = csr_wd[7];
        end

        if (csr_we && !trap_valid) begin
            case (csr_waddr)
                A_MEPC:   mepc_d   = csr_wd & ALIGN_MASK;
                A_MCAUSE: mcause_d = csr_wd;
                A_MTVAL:  mtval_d  = csr_wd;
                default:  ;
            endcase
        end

        if (csr_we) begin
            case (csr_waddr)
                A_MIE:       mtie_d     = csr_wd[7];
                A_MTVEC:     mtvec_d    = csr_wd & ALIGN_MASK;
                A_MSCRATCH:  mscratch_d = csr_wd;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wd};
                A_MCYCLEH:   mcycle_d   = {csr_wd, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wd};
                A_MINSTRETH: minstret_d = {csr_wd, minstret_q[31:0]};
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file with hand-written counter,
// wrap and mid-run reset sequences.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [31:0] csr_rd;
    logic        csr_illegal;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wd;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret;
    logic        irq_timer;
    logic        irq_pending;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;

    int errors = 0;
    int checks = 0;

    csr_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_rd       (csr_rd),
        .csr_illegal  (csr_illegal),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wd       (csr_wd),
        .instr_retire (instr_retire),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_val     (trap_val),
        .mret         (mret),
        .irq_timer    (irq_timer),
        .irq_pending  (irq_pending),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wd;
        logic        trap;
        logic [31:0] tpc;
        logic [31:0] tcause;
        logic [31:0] tval;
        logic        mret;
        logic        irq;
        logic [11:0] raddr;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [11:0] waddr, input logic [31:0] wd,
                                input logic trap, input logic [31:0] tpc, input logic [31:0] tcause,
                                input logic [31:0] tval, input logic mr, input logic irq,
                                input logic [11:0] raddr, input logic [31:0] exp_rd,
                                input logic exp_ill, input logic exp_irq);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wd = wd;
        v.trap = trap; v.tpc = tpc; v.tcause = tcause; v.tval = tval;
        v.mret = mr; v.irq = irq; v.raddr = raddr;
        v.exp_rd = exp_rd; v.exp_ill = exp_ill; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        csr_we = 1'b0; csr_waddr = '0; csr_wd = '0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; trap_val = '0;
        mret = 1'b0; instr_retire = 1'b0;
    endtask

    // Drive one vector for one edge, then read the target CSR after the edge
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        csr_we = v.we; csr_waddr = v.waddr; csr_wd = v.wd;
        trap_valid = v.trap; trap_pc = v.tpc; trap_cause = v.tcause; trap_val = v.tval;
        mret = v.mret; irq_timer = v.irq;
        @(posedge clk);
        #1;
        clear_strobes();
        csr_addr = v.raddr;
        #1;
        check($sformatf("vec%0d_rd", idx), csr_rd, v.exp_rd);
        check($sformatf("vec%0d_illegal", idx), 32'(csr_illegal), 32'(v.exp_ill));
        check($sformatf("vec%0d_irq_pending", idx), 32'(irq_pending), 32'(v.exp_irq));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_we = 1'b1; csr_waddr = a; csr_wd = d;
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rd, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        irq_timer = 1'b0;
        csr_addr = 12'h305;
        clear_strobes();

        //        we   waddr    wd            trap tpc           tcause        tval          mret irq raddr    exp_rd        ill  irq
        vecs.push_back(mk(1, 12'h305, 32'h0000_1233, 0, 0,            0,            0,            0, 0, 12'h305, 32'h0000_1230, 0, 0));
        vecs.push_back(mk(1, 12'h340, 32'hDEAD_BEEF, 0, 0,            0,            0,            0, 0, 12'h340, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(1, 12'hC02, 32'h0000_0055, 0, 0,            0,            0,            0, 0, 12'hC02, 32'h0,         0, 0));
        vecs.push_back(mk(1, 12'h301, 32'h0,         0, 0,            0,            0,            0, 0, 12'h301, 32'h4000_0100, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h7C0, 32'h0,         1, 0));
        vecs.push_back(mk(1, 12'h300, 32'h0000_0088, 0, 0,            0,            0,            0, 0, 12'h300, 32'h0000_1888, 0, 0));
        vecs.push_back(mk(1, 12'h300, 32'h0000_0008, 0, 0,            0,            0,            0, 0, 12'h300, 32'h0000_1808, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         1, 32'h0000_2006, 32'h8000_0007, 32'h0000_0123, 0, 0, 12'h341, 32'h0000_2004, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h342, 32'h8000_0007, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h343, 32'h0000_0123, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h300, 32'h0000_1880, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            1, 0, 12'h300, 32'h0000_1888, 0, 0));
        vecs.push_back(mk(1, 12'h341, 32'h0000_0040, 1, 32'h0000_3003, 32'h0000_0002, 32'h0,         1, 0, 12'h341, 32'h0000_3000, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h300, 32'h0000_1880, 0, 0));
        vecs.push_back(mk(1, 12'h340, 32'h0000_0011, 1, 32'h0000_0010, 32'h0000_0003, 32'h0000_0005, 0, 0, 12'h340, 32'h0000_0011, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h300, 32'h0000_1800, 0, 0));
        vecs.push_back(mk(1, 12'h300, 32'h0000_0008, 0, 0,            0,            0,            1, 0, 12'h300, 32'h0000_1880, 0, 0));
        vecs.push_back(mk(1, 12'h304, 32'hFFFF_FFFF, 0, 0,            0,            0,            0, 1, 12'h304, 32'h0000_0080, 0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 1, 12'h344, 32'h0000_0080, 0, 0));
        vecs.push_back(mk(1, 12'h300, 32'h0000_0008, 0, 0,            0,            0,            0, 1, 12'h300, 32'h0000_1808, 0, 1));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'h344, 32'h0,         0, 0));
        vecs.push_back(mk(0, 12'h0,   32'h0,         0, 0,            0,            0,            0, 0, 12'hF14, 32'h0,         0, 0));
        vecs.push_back(mk(1, 12'h341, 32'h0000_1237, 0, 0,            0,            0,            0, 0, 12'h341, 32'h0000_1234, 0, 0));

        // Power-on reset values
        #12;
        rd_check("por_mtvec", 12'h305, 32'h0000_0100);
        rd_check("por_mstatus", 12'h300, 32'h0000_1800);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        check("trap_vector", trap_vector, 32'h0000_1230);
        check("mepc_out", mepc_out, 32'h0000_1234);

        // minstret carry from low into high on a retire
        wr(12'hB02, 32'hFFFF_FFFF);
        wr(12'hB82, 32'h0);
        rd_check("minstret_pre_lo", 12'hB02, 32'hFFFF_FFFF);
        @(negedge clk);
        instr_retire = 1'b1;
        @(posedge clk);
        #1;
        instr_retire = 1'b0;
        rd_check("minstret_lo", 12'hB02, 32'h0);
        rd_check("minstret_hi", 12'hB82, 32'h0000_0001);
        rd_check("instreth_shadow", 12'hC82, 32'h0000_0001);

        // mcycle write suppresses that cycle's increment
        wr(12'hB00, 32'h0000_0007);
        rd_check("mcycle_write", 12'hB00, 32'h0000_0007);
        @(posedge clk);
        #1;
        rd_check("mcycle_next", 12'hB00, 32'h0000_0008);
        rd_check("cycle_shadow", 12'hC00, 32'h0000_0008);

        // 64-bit wrap of mcycle
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd_check("mcycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
        rd_check("mcycle_max_hi", 12'hB80, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rd_check("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd_check("mcycle_wrap_hi", 12'hB80, 32'h0);

        // Mid-run asynchronous reset with interrupt enabled and a pending write
        wr(12'h300, 32'h0000_0008);
        wr(12'h304, 32'h0000_0080);
        irq_timer = 1'b1;
        #1;
        check("irq_before_reset", 32'(irq_pending), 32'h1);
        @(negedge clk);
        csr_we = 1'b1; csr_waddr = 12'h340; csr_wd = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        rd_check("rst_mtvec", 12'h305, 32'h0000_0100);
        rd_check("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_check("rst_mcycle", 12'hB00, 32'h0);
        rd_check("rst_mie", 12'h304, 32'h0);
        check("rst_irq_pending", 32'(irq_pending), 32'h0);
        @(posedge clk);
        #1;
        clear_strobes();
        rd_check("rst_mscratch", 12'h340, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("rel_mcycle0", 12'hB00, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rd_check("rel_mcycle5", 12'hB00, 32'h0000_0005);
        irq_timer = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
